// File: rtl/core_to_ts.sv
// rtl/core_to_ts.sv - per-core result slots, round-robin arbiter and valid/ready forwarder to the task scheduler
// Optional accepted-message counter enabled by CORE_TO_TS_STATS_EN.
module core_to_ts #(
    parameter int NUM_CORES = 16,
    parameter int MSG_W     = 16,
    parameter int ID_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CORES-1:0]       res_val_bus,
    input  logic [NUM_CORES*MSG_W-1:0] res_data_bus,
    output logic [NUM_CORES-1:0]       res_ack_bus,
    output logic [MSG_W-1:0]           mess_to_ts,
    output logic [ID_W-1:0]            core_id_to_ts,
    output logic                       val_to_ts,
    input  logic                       ts_ready,
    output logic [15:0]                msg_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [MSG_W-1:0]       slot_data_q [NUM_CORES];
    logic [NUM_CORES-1:0]   slot_full_q, slot_full_d;
    logic [NUM_CORES-1:0]   capture, drain;
    logic [NUM_CORES-1:0]   ack_q;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [MSG_W-1:0]       out_data_q, out_data_d;
    logic [ID_W-1:0]        out_id_q, out_id_d;
    logic                   found;
    logic [ID_W-1:0]        winner;
    logic                   out_free;

    // Capture uses the pre-edge full flag, so a slot drained this edge refills one edge later.
    assign capture     = res_val_bus & ~slot_full_q;
    assign slot_full_d = (slot_full_q & ~drain) | capture;

    // First full slot scanning from ptr; index arithmetic wraps since NUM_CORES is 2**ID_W.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx    = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = ptr_q + ID_W'(k);
            if (!found && slot_full_q[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign out_free = (state_q == S_IDLE) || ts_ready;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        ptr_d      = ptr_q;
        drain      = '0;
        if (out_free) begin
            if (found) begin
                state_d       = S_SEND;
                out_data_d    = slot_data_q[winner];
                out_id_d      = winner;
                ptr_d         = winner + ID_W'(1);
                drain[winner] = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_full_q <= '0;
            ack_q       <= '0;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            slot_full_q <= slot_full_d;
            ack_q       <= capture;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    // Slot payload needs no reset: it is only ever read behind its full flag.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (capture[i]) begin
                slot_data_q[i] <= res_data_bus[i*MSG_W +: MSG_W];
            end
        end
    end

    assign res_ack_bus   = ack_q;
    assign mess_to_ts    = out_data_q;
    assign core_id_to_ts = out_id_q;
    assign val_to_ts     = (state_q == S_SEND);

`ifdef CORE_TO_TS_STATS_EN
    logic [15:0] msg_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_count_q <= 16'h0000;
        end else if (val_to_ts && ts_ready) begin
            msg_count_q <= msg_count_q + 16'h0001;
        end
    end

    assign msg_count = msg_count_q;
`else
    assign msg_count = 16'h0000;
`endif

endmodule

// File: tb/tb_core_to_ts.sv
// tb/tb_core_to_ts.sv - directed bench for core_to_ts with a queue-based slot/arbiter model
module tb_core_to_ts;
    localparam int N = 16;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     res_val_bus;
    logic [N*W-1:0]   res_data_bus;
    logic [N-1:0]     res_ack_bus;
    logic [W-1:0]     mess_to_ts;
    logic [3:0]       core_id_to_ts;
    logic             val_to_ts;
    logic             ts_ready;
    logic [15:0]      msg_count;

    always #5 clk = ~clk;

    core_to_ts #(.NUM_CORES(N), .MSG_W(W), .ID_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .res_val_bus   (res_val_bus),
        .res_data_bus  (res_data_bus),
        .res_ack_bus   (res_ack_bus),
        .mess_to_ts    (mess_to_ts),
        .core_id_to_ts (core_id_to_ts),
        .val_to_ts     (val_to_ts),
        .ts_ready      (ts_ready),
        .msg_count     (msg_count)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    bit          m_full [N];
    logic [15:0] m_data [N];
    bit          m_ack  [N];
    bit          m_val;
    logic [15:0] m_mess;
    int          m_id;
    int          m_ptr;
    logic [15:0] m_cnt;
    int          acc_total;
    int          cyc = 0;
    int          acc_id  [$];
    logic [15:0] acc_dat [$];
    int          acc_cyc [$];

    // per-core pending messages (front is what the core presents)
    logic [15:0] cq [N][$];
    int          ack_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit cap [N];
        int w;
        cyc++;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_full[i] = 1'b0;
                m_ack[i]  = 1'b0;
            end
            m_val = 1'b0; m_mess = 16'h0; m_id = 0; m_ptr = 0;
            m_cnt = 16'h0; acc_total = 0;
        end else begin
            for (int i = 0; i < N; i++) cap[i] = res_val_bus[i] && !m_full[i];
            if (m_val && ts_ready) begin
                acc_id.push_back(m_id);
                acc_dat.push_back(m_mess);
                acc_cyc.push_back(cyc);
                m_cnt = m_cnt + 16'h1;
                acc_total++;
            end
            if (!m_val || ts_ready) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && m_full[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                if (w >= 0) begin
                    m_val = 1'b1; m_mess = m_data[w]; m_id = w;
                    m_full[w] = 1'b0; m_ptr = (w + 1) % N;
                end else begin
                    m_val = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                m_ack[i] = cap[i];
                if (cap[i]) begin
                    m_full[i] = 1'b1;
                    m_data[i] = res_data_bus[i*W +: W];
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // per-cycle comparison of DUT against model
    initial forever begin
        logic [N-1:0] ea;
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < N; i++) ea[i] = m_ack[i];
            chk("cyc_val", 32'(val_to_ts), 32'(m_val));
            chk("cyc_ack", 32'(res_ack_bus), 32'(ea));
            if (m_val) begin
                chk("cyc_mess", 32'(mess_to_ts), 32'(m_mess));
                chk("cyc_id", 32'(core_id_to_ts), 32'(m_id));
            end
`ifdef CORE_TO_TS_STATS_EN
            chk("cyc_count", 32'(msg_count), 32'(m_cnt));
`else
            chk("cyc_count", 32'(msg_count), 32'h0);
`endif
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            res_val_bus[i] = (cq[i].size() > 0);
            res_data_bus[i*W +: W] = (cq[i].size() > 0) ? cq[i][0] : 16'h0;
        end
    endtask

    // one clock: cores react to ack by moving to their next message in the same cycle
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (m_ack[i]) begin
                ack_seen++;
                if (cq[i].size() > 0) void'(cq[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) cq[i].delete();
        drive();
        step();
        rst = 1'b0;
        acc_id.delete(); acc_dat.delete(); acc_cyc.delete();
        ack_seen = 0;
    endtask

    initial begin
        int f;
        int seq [3];
        rst = 1'b1;
        ts_ready = 1'b0;
        res_val_bus = '0;
        res_data_bus = '0;
        do_reset();
        chk_en = 1'b1;
        chk("rst_val", 32'(val_to_ts), 32'h0);
        chk("rst_ack", 32'(res_ack_bus), 32'h0);
        chk("rst_mess", 32'(mess_to_ts), 32'h0);
        chk("rst_id", 32'(core_id_to_ts), 32'h0);

        // single message from core 5
        ts_ready = 1'b1;
        cq[5].push_back(16'hA5A5);
        drive();
        step();
        chk("t1_ack", 32'(res_ack_bus), 32'h0020);
        chk("t1_val_early", 32'(m_val), 32'h0);
        step();
        chk("t1_ack_off", 32'(res_ack_bus), 32'h0);
        chk("t1_val", 32'(m_val), 32'h1);
        chk("t1_mess", 32'(m_mess), 32'hA5A5);
        chk("t1_id", 32'(m_id), 32'h5);
        step();
        chk("t1_one_cycle", 32'(m_val), 32'h0);

        // all-core burst
        do_reset();
        ts_ready = 1'b1;
        for (int i = 0; i < N; i++) cq[i].push_back(16'h1000 + 16'(i));
        drive();
        repeat (22) step();
        chk("t2_count", 32'(acc_id.size()), 32'd16);
        chk("t2_acks", 32'(ack_seen), 32'd16);
        if (acc_id.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk("t2_id", 32'(acc_id[i]), 32'(i));
                chk("t2_data", 32'(acc_dat[i]), 32'h1000 + 32'(i));
                chk("t2_nogap", 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
            end
        end
`ifndef CORE_TO_TS_STATS_EN
        chk("t6_nostats", 32'(msg_count), 32'h0);
`endif

        // backpressure
        do_reset();
        ts_ready = 1'b0;
        cq[2].push_back(16'h2000); cq[2].push_back(16'h2001);
        cq[7].push_back(16'h7000);
        cq[9].push_back(16'h9000);
        drive();
        step();
        chk("t3_ack3", 32'(res_ack_bus), 32'h0284);
        step();
        chk("t3_core2_no_ack", 32'(res_ack_bus), 32'h0);
        step();
        chk("t3_core2_ack", 32'(res_ack_bus), 32'h0004);
        for (int k = 0; k < 8; k++) begin
            chk("t3_hold_val", 32'(val_to_ts), 32'h1);
            chk("t3_hold_id", 32'(core_id_to_ts), 32'h2);
            chk("t3_hold_mess", 32'(mess_to_ts), 32'h2000);
            step();
        end
        ts_ready = 1'b1;
        repeat (8) step();
        chk("t3_count", 32'(acc_id.size()), 32'd4);
        if (acc_id.size() == 4) begin
            chk("t3_o0", 32'(acc_id[0]), 32'd2);
            chk("t3_o1", 32'(acc_id[1]), 32'd7);
            chk("t3_o2", 32'(acc_id[2]), 32'd9);
            chk("t3_o3", 32'(acc_id[3]), 32'd2);
            chk("t3_d3", 32'(acc_dat[3]), 32'h2001);
        end

        // fairness and pointer wrap
        do_reset();
        ts_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cq[14].push_back(16'hE000 + 16'(k));
            cq[15].push_back(16'hF000 + 16'(k));
        end
        drive();
        repeat (4) step();
        for (int k = 0; k < 6; k++) cq[0].push_back(16'h0A00 + 16'(k));
        drive();
        repeat (40) step();
        f = -1;
        for (int i = 0; i < acc_id.size(); i++) if (f < 0 && acc_id[i] == 0) f = i;
        chk("t4_core0_seen", 32'(f > 0), 32'h1);
        seq[0] = 0; seq[1] = 14; seq[2] = 15;
        if (f > 0 && acc_id.size() >= f + 9) begin
            chk("t4_before", 32'(acc_id[f-1]), 32'd15);
            chk("t4_first_data", 32'(acc_dat[f]), 32'h0A00);
            for (int j = 0; j < 9; j++) begin
                chk("t4_order", 32'(acc_id[f+j]), 32'(seq[j % 3]));
                chk("t4_nogap", 32'(acc_cyc[f+j] - acc_cyc[f]), 32'(j));
            end
        end

        // reset mid-flight
        do_reset();
        ts_ready = 1'b0;
        for (int i = 3; i <= 6; i++) cq[i].push_back(16'h3300 + 16'(i));
        drive();
        step();
        step();
        chk("t5_val_before", 32'(val_to_ts), 32'h1);
        chk("t5_id_before", 32'(m_id), 32'h3);
        rst = 1'b1;
        for (int i = 0; i < N; i++) cq[i].delete();
        drive();
        step();
        rst = 1'b0;
        chk("t5_val", 32'(val_to_ts), 32'h0);
        chk("t5_mess", 32'(mess_to_ts), 32'h0);
        chk("t5_id", 32'(core_id_to_ts), 32'h0);
        chk("t5_ack", 32'(res_ack_bus), 32'h0);
        acc_id.delete(); acc_dat.delete(); acc_cyc.delete();
        ts_ready = 1'b1;
        cq[9].push_back(16'h9999);
        cq[2].push_back(16'h2222);
        drive();
        repeat (8) step();
        chk("t5_count", 32'(acc_id.size()), 32'd2);
        if (acc_id.size() == 2) begin
            chk("t5_first", 32'(acc_id[0]), 32'd2);
            chk("t5_first_data", 32'(acc_dat[0]), 32'h2222);
            chk("t5_second", 32'(acc_id[1]), 32'd9);
        end

`ifdef CORE_TO_TS_STATS_EN
        // counter wrap over 70000 accepted transfers with periodic stalls
        do_reset();
        for (int c = 0; c < 90000 && acc_total < 70000; c++) begin
            for (int i = 0; i < 4; i++)
                if (cq[i].size() < 2) cq[i].push_back(16'(c));
            drive();
            ts_ready = (acc_total < 70000) && (c % 16 != 15);
            step();
        end
        chk("t6_total", 32'(acc_total), 32'd70000);
        ts_ready = 1'b0;
        repeat (3) step();
        chk("t6_count", 32'(msg_count), 32'd4464);
        chk("t6_model_count", 32'(m_cnt), 32'd4464);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
